md_unit: RTL and testbench

- Parametrised multiply/divide unit with HI/LO registers; sits in the E stage beside the ALU.
- Accepts MULT/DIV family and MTHI/MTLO operations and runs multi-cycle operations with a busy counter.
- Hazard control uses busy to stall later HI/LO users; CP0 IntReq drives cancel so an operation in a squashed E stage is not started.

---
 rtl/md_unit.sv | 136 +++++++++++++
 tb/tb_md_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Optional MADD/MADDU/MSUB/MSUBU accumulation is enabled by defining MD_UNIT_MADD_EN.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } op_e;

  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   pend_hi, pend_lo;
  logic               accept;

  logic               multi;
  logic [CNT_W-1:0]   latency;
  logic [WIDTH-1:0]   res_hi, res_lo;

  logic               mul_signed, div_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, quo_mag, rem_mag, quo, rem;

  assign busy   = (count != '0);
  assign accept = start & ~busy & ~cancel;

  // Shared datapath: sign-extending to 2*WIDTH makes one multiplier serve both signednesses.
  always_comb begin
    mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    div_signed = (op == OP_DIV);
    ext_a = mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    ext_b = mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod  = ext_a * ext_b;

    // MIN / -1 needs no special case: |MIN| as unsigned, negated, wraps back to MIN.
    a_neg   = div_signed & a[WIDTH-1];
    b_neg   = div_signed & b[WIDTH-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    quo_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
    rem_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
    quo     = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
    rem     = a_neg ? -rem_mag : rem_mag;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    multi   = 1'b0;
    latency = '0;
    res_hi  = hi;
    res_lo  = lo;
    case (op)
      OP_MULT, OP_MULTU: begin
        multi            = 1'b1;
        latency          = CNT_W'(MULT_CYCLES);
        {res_hi, res_lo} = prod;
      end
      OP_DIV, OP_DIVU: begin
        multi   = 1'b1;
        latency = CNT_W'(DIV_CYCLES);
        if (b == '0) begin
          res_lo = '1;
          res_hi = a;
        end else begin
          res_lo = quo;
          res_hi = rem;
        end
      end
`ifdef MD_UNIT_MADD_EN
      OP_MADD, OP_MADDU: begin
        multi            = 1'b1;
        latency          = CNT_W'(MULT_CYCLES);
        {res_hi, res_lo} = {hi, lo} + prod;
      end
      OP_MSUB, OP_MSUBU: begin
        multi            = 1'b1;
        latency          = CNT_W'(MULT_CYCLES);
        {res_hi, res_lo} = {hi, lo} - prod;
      end
`endif
      default: ;
    endcase
  end

  // The result is computed at accept and parked in pend_*; hi/lo only move when busy falls.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else if (accept) begin
      if (op == OP_MTHI) hi <= a;
      if (op == OP_MTLO) lo <= a;
      if (multi) begin
        count   <= latency;
        pend_hi <= res_hi;
        pend_lo <= res_lo;
      end
    end else if (busy) begin
      count <= count - CNT_W'(1);
      if (count == CNT_W'(1)) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO, a monitor checks on busy fall or probe.
// Define MD_UNIT_MADD_EN for both bench and RTL to exercise the accumulate operations.
module tb_md_unit;

  localparam int W      = 32;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    op = '0;
  logic [W-1:0]  a = '0, b = '0;
  logic          cancel = 1'b0;
  logic          busy;
  logic [W-1:0]  hi, lo;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi, lo, old_hi, old_lo;
    int           cycles;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  logic         probe = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: architectural result of one accepted operation.
  function automatic exp_t ref_model(input logic [3:0] o, input logic [W-1:0] x, y,
                                     input logic [W-1:0] h, l);
    exp_t         e;
    logic [63:0]  p;
    longint       q, r;
    e.old_hi = h; e.old_lo = l; e.hi = h; e.lo = l; e.cycles = 0;
    p = longint'($signed(x)) * longint'($signed(y));
    case (o)
      4'd0: begin {e.hi, e.lo} = p; e.cycles = MULT_N; end
      4'd1: begin {e.hi, e.lo} = {32'b0, x} * {32'b0, y}; e.cycles = MULT_N; end
      4'd2, 4'd3: begin
        e.cycles = DIV_N;
        if (y == 0) begin
          e.lo = '1; e.hi = x;
        end else if (o == 4'd2) begin
          q = longint'($signed(x)) / longint'($signed(y));
          r = longint'($signed(x)) % longint'($signed(y));
          e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          e.lo = x / y; e.hi = x % y;
        end
      end
      4'd4: e.hi = x;
      4'd5: e.lo = x;
`ifdef MD_UNIT_MADD_EN
      4'd6: begin {e.hi, e.lo} = {h, l} + p; e.cycles = MULT_N; end
      4'd7: begin {e.hi, e.lo} = {h, l} + {32'b0, x} * {32'b0, y}; e.cycles = MULT_N; end
      4'd8: begin {e.hi, e.lo} = {h, l} - p; e.cycles = MULT_N; end
      4'd9: begin {e.hi, e.lo} = {h, l} - {32'b0, x} * {32'b0, y}; e.cycles = MULT_N; end
`endif
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: pops on a probe request or when busy falls.
  logic         prev_busy = 1'b0;
  int           busy_cnt = 0;
  logic         hold_ok = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (probe) begin
      if (sb.size() == 0) check("probe_queue_empty", 1, 0);
      else begin
        e = sb.pop_front();
        check("probe_hi", hi, e.hi);
        check("probe_lo", lo, e.lo);
        check("probe_busy", busy, 0);
      end
    end
    if (busy) begin
      if (!prev_busy) begin busy_cnt = 0; hold_ok = 1'b1; end
      busy_cnt++;
      if (sb.size() != 0 && (hi !== sb[0].old_hi || lo !== sb[0].old_lo)) hold_ok = 1'b0;
    end else if (prev_busy) begin
      if (sb.size() == 0) check("done_queue_empty", 1, 0);
      else begin
        e = sb.pop_front();
        check("done_hi", hi, e.hi);
        check("done_lo", lo, e.lo);
        check("busy_cycles", 64'(busy_cnt), 64'(e.cycles));
        check("hold_during_busy", hold_ok, 1);
      end
    end
    prev_busy = busy;
  end

  task automatic drive(input logic [3:0] o, input logic [W-1:0] x, y, input logic c);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; cancel = c;
    @(posedge clk);
    #1 start = 1'b0; cancel = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) check("busy_timeout", 1, 0);
  endtask

  task automatic request_probe();
    probe = 1'b1;
    @(negedge clk);
    #1 probe = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, y, input logic c);
    exp_t e;
    e = ref_model(o, x, y, m_hi, m_lo);
    drive(o, x, y, c);
    if (c) begin
      e.hi = m_hi; e.lo = m_lo; e.cycles = 0;
    end
    m_hi = e.hi; m_lo = e.lo;
    sb.push_back(e);
    if (e.cycles > 0) begin
      @(negedge clk);
      wait_idle();
    end else begin
      request_probe();
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    e = '{hi: 0, lo: 0, old_hi: 0, old_lo: 0, cycles: 0};
    sb.push_back(e);
    request_probe();
    @(negedge clk) reset = 1'b1;

    do_op(4'd4, 32'h1234_5678, 0, 0);
    do_op(4'd5, 32'hCAFE_BABE, 0, 0);
    do_op(4'd0, 32'hFFFF_FFFF, 2, 0);
    do_op(4'd1, 32'hFFFF_FFFF, 2, 0);
    do_op(4'd2, 32'hFFFF_FFF9, 2, 0);
    do_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(4'd3, 5, 0, 0);
    do_op(4'd0, 7, 9, 1);

    // Cancel pulse in the middle of busy must not stop the commit.
    e = ref_model(4'd0, 32'h0001_0003, 32'h0002_0005, m_hi, m_lo);
    drive(4'd0, 32'h0001_0003, 32'h0002_0005, 0);
    sb.push_back(e); m_hi = e.hi; m_lo = e.lo;
    @(negedge clk); cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    wait_idle();

    // A start while busy is ignored.
    e = ref_model(4'd3, 32'd1000, 32'd7, m_hi, m_lo);
    drive(4'd3, 32'd1000, 32'd7, 0);
    sb.push_back(e); m_hi = e.hi; m_lo = e.lo;
    repeat (2) @(negedge clk);
    drive(4'd5, 32'hDEAD_BEEF, 0, 0);
    drive(4'd0, 32'h1234, 32'h5678, 0);
    wait_idle();

    // Reset at busy cycle 3 of a divide aborts it asynchronously.
    e = ref_model(4'd2, 32'd100, 32'd3, m_hi, m_lo);
    drive(4'd2, 32'd100, 32'd3, 0);
    e.hi = 0; e.lo = 0; e.cycles = 3;
    sb.push_back(e);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_busy", busy, 0);
    check("async_reset_hi", hi, 0);
    check("async_reset_lo", lo, 0);
    m_hi = 0; m_lo = 0;
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    do_op(4'd5, 32'h0BAD_F00D, 0, 0);

`ifdef MD_UNIT_MADD_EN
    do_op(4'd4, 0, 0, 0);
    do_op(4'd5, 32'hFFFF_FFFF, 0, 0);
    do_op(4'd7, 1, 1, 0);
    do_op(4'd4, 0, 0, 0);
    do_op(4'd5, 0, 0, 0);
    do_op(4'd8, 1, 1, 0);
`else
    do_op(4'd6, 32'h55, 32'h66, 0);
`endif
    do_op(4'd12, 32'h77, 32'h88, 0);

    for (int i = 0; i < 40; i++)
      do_op(4'($urandom_range(0, 15)), rand_operand(), rand_operand(), $urandom_range(0, 9) == 0);

    repeat (2) @(negedge clk);
    check("queue_drained", 64'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

endmodule
